// File: rtl/id_operand_read_if.sv
// id_operand_read_if: decode-stage bus bundle.
// master = fetch / write-back / redirect side; slave = the operand-read block.
//
// Handshake: IF_valid qualifies IF_IR and IF_PC_plus_4 in the cycle it is
// high. Stall=1 means the block refuses the offered instruction this cycle,
// and upstream must present the same IF_IR/IF_PC_plus_4 again next cycle.
// ID_valid qualifies the ID_* pipeline outputs. WB_RegWrite qualifies
// WB_WriteBackReg/WB_WriteBackData, and a write is always accepted.
// flush has priority over Stall, on this side and upstream.
interface id_operand_read_if;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC_plus_4;
    logic        IF_valid;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteBackReg;
    logic [31:0] WB_WriteBackData;
    logic        flush;
    logic        Stall;
    logic [31:0] ID_IR;
    logic [31:0] ID_PC_plus_4;
    logic [31:0] ID_RegA;
    logic [31:0] ID_RegB;
    logic        ID_valid;

    modport master (
        output IF_IR, IF_PC_plus_4, IF_valid,
        output WB_RegWrite, WB_WriteBackReg, WB_WriteBackData,
        output flush,
        input  Stall, ID_IR, ID_PC_plus_4, ID_RegA, ID_RegB, ID_valid
    );

    modport slave (
        input  IF_IR, IF_PC_plus_4, IF_valid,
        input  WB_RegWrite, WB_WriteBackReg, WB_WriteBackData,
        input  flush,
        output Stall, ID_IR, ID_PC_plus_4, ID_RegA, ID_RegB, ID_valid
    );
endinterface

// File: rtl/id_operand_read.sv
// id_operand_read: decode-stage register file read, load-use hazard detection
// and the ID/EX pipeline register.
// The GPR array is written by write-back. Reads bypass a same-cycle WB write.
// Optional macro ID_STALL_COUNT_EN adds a saturating stall_count output.
module id_operand_read #(
    parameter logic [5:0]  LOAD_OPCODE = 6'b100011,
    parameter logic [31:0] SP_INIT     = 32'h0000_07fc
) (
    input  logic               clk,
    input  logic               reset,
    id_operand_read_if.slave   bus
`ifdef ID_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    logic [31:0] gpr [32];
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  loadRt;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        hazard;

    // Register file: $sp starts at SP_INIT. Writes to $0 are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= (i == 29) ? SP_INIT : 32'h0;
            end
        end else if (bus.WB_RegWrite && (bus.WB_WriteBackReg != 5'd0)) begin
            gpr[bus.WB_WriteBackReg] <= bus.WB_WriteBackData;
        end
    end

    // Operand read with write-through bypass. $0 reads zero even during a WB write to it.
    always_comb begin
        rs  = bus.IF_IR[25:21];
        rt  = bus.IF_IR[20:16];
        opA = 32'h0;
        opB = 32'h0;
        if (rs != 5'd0) begin
            opA = (bus.WB_RegWrite && (bus.WB_WriteBackReg == rs)) ? bus.WB_WriteBackData : gpr[rs];
        end
        if (rt != 5'd0) begin
            opB = (bus.WB_RegWrite && (bus.WB_WriteBackReg == rt)) ? bus.WB_WriteBackData : gpr[rt];
        end
    end

    // Load-use hazard: the load in ID/EX targets a register the incoming instruction
    // may read. Matching on rs/rt alone is deliberately conservative.
    always_comb begin
        loadRt = bus.ID_IR[20:16];
        hazard = reset
              && bus.ID_valid
              && (bus.ID_IR[31:26] == LOAD_OPCODE)
              && (loadRt != 5'd0)
              && bus.IF_valid
              && ((loadRt == rs) || (loadRt == rt));
    end

    assign bus.Stall = hazard;

    // ID/EX register: flush beats stall. Both insert a bubble, and PC+4 holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ID_IR        <= 32'h0;
            bus.ID_PC_plus_4 <= 32'h0;
            bus.ID_RegA      <= 32'h0;
            bus.ID_RegB      <= 32'h0;
            bus.ID_valid     <= 1'b0;
        end else if (bus.flush || hazard) begin
            bus.ID_IR        <= 32'h0;
            bus.ID_RegA      <= 32'h0;
            bus.ID_RegB      <= 32'h0;
            bus.ID_valid     <= 1'b0;
        end else begin
            bus.ID_IR        <= bus.IF_IR;
            bus.ID_PC_plus_4 <= bus.IF_PC_plus_4;
            bus.ID_RegA      <= opA;
            bus.ID_RegB      <= opB;
            bus.ID_valid     <= bus.IF_valid;
        end
    end

`ifdef ID_STALL_COUNT_EN
    // Count stall cycles that were not overridden by a flush. The count saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 32'h0;
        end else if (hazard && !bus.flush && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_operand_read.sv
// tb_id_operand_read: bench for id_operand_read.
// It runs a vector table, then hand-written reset and flush sequences, then random reads and writes.
module tb_id_operand_read;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_operand_read_if bus();

`ifdef ID_STALL_COUNT_EN
    logic [31:0] stallCount;
`endif

    id_operand_read dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ID_STALL_COUNT_EN
        ,
        .stall_count (stallCount)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [128:0] exp_q[$];   // {IR, PC+4, RegA, RegB, valid}

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        flush;
        logic        expStall;
        logic [31:0] expIr;
        logic [31:0] expPc;
        logic [31:0] expA;
        logic [31:0] expB;
        logic        expValid;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic valid,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic flush);
        @(negedge clk);
        bus.IF_IR            = ir;
        bus.IF_PC_plus_4     = pc;
        bus.IF_valid         = valid;
        bus.WB_RegWrite      = we;
        bus.WB_WriteBackReg  = wreg;
        bus.WB_WriteBackData = wdata;
        bus.flush            = flush;
    endtask

    task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic valid);
        exp_q.push_back({ir, pc, a, b, valid});
    endtask

    task automatic compare_out(input string tag);
        logic [128:0] e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
        end else begin
            checks--;
            e = exp_q.pop_front();
            check32({tag, ".ID_IR"}, bus.ID_IR, e[128:97]);
            check32({tag, ".ID_PC_plus_4"}, bus.ID_PC_plus_4, e[96:65]);
            check32({tag, ".ID_RegA"}, bus.ID_RegA, e[64:33]);
            check32({tag, ".ID_RegB"}, bus.ID_RegB, e[32:1]);
            check32({tag, ".ID_valid"}, {31'h0, bus.ID_valid}, {31'h0, e[0]});
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[15];
    logic [31:0] model[32];

    initial begin
        bus.IF_IR = 32'h0; bus.IF_PC_plus_4 = 32'h0; bus.IF_valid = 1'b0;
        bus.WB_RegWrite = 1'b0; bus.WB_WriteBackReg = 5'd0; bus.WB_WriteBackData = 32'h0;
        bus.flush = 1'b0;
        reset = 1'b0;

        //           ir            pc     v  we reg wdata          fl  stall expIr         expPc  expA          expB          expV
        vecs[0]  = '{32'h03A0_0000, 32'd4,  1, 0, 0, 32'h0,         0,  0, 32'h03A0_0000, 32'd4,  32'h0000_07fc, 32'h0,         1};
        vecs[1]  = '{32'h0108_4020, 32'd8,  1, 1, 8, 32'hDEAD_BEEF, 0,  0, 32'h0108_4020, 32'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[2]  = '{32'h0108_4020, 32'd12, 1, 0, 0, 32'h0,         0,  0, 32'h0108_4020, 32'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[3]  = '{32'h0000_0020, 32'd16, 1, 1, 0, 32'h1234_5678, 0,  0, 32'h0000_0020, 32'd16, 32'h0,         32'h0,         1};
        vecs[4]  = '{32'h001D_0020, 32'd20, 1, 0, 0, 32'h0,         0,  0, 32'h001D_0020, 32'd20, 32'h0,         32'h0000_07fc, 1};
        vecs[5]  = '{32'h8D09_0000, 32'd24, 1, 0, 0, 32'h0,         0,  0, 32'h8D09_0000, 32'd24, 32'hDEAD_BEEF, 32'h0,         1};
        vecs[6]  = '{32'h012B_5020, 32'd28, 1, 0, 0, 32'h0,         0,  1, 32'h0,         32'd24, 32'h0,         32'h0,         0};
        vecs[7]  = '{32'h012B_5020, 32'd28, 1, 1, 9, 32'h0000_0055, 0,  0, 32'h012B_5020, 32'd28, 32'h0000_0055, 32'h0,         1};
        vecs[8]  = '{32'h0108_4020, 32'd32, 0, 0, 0, 32'h0,         0,  0, 32'h0108_4020, 32'd32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[9]  = '{32'h8FA8_0000, 32'd36, 1, 0, 0, 32'h0,         0,  0, 32'h8FA8_0000, 32'd36, 32'h0000_07fc, 32'hDEAD_BEEF, 1};
        vecs[10] = '{32'h0108_4020, 32'd40, 1, 0, 0, 32'h0,         1,  1, 32'h0,         32'd36, 32'h0,         32'h0,         0};
        vecs[11] = '{32'h8C00_0000, 32'd44, 1, 0, 0, 32'h0,         0,  0, 32'h8C00_0000, 32'd44, 32'h0,         32'h0,         1};
        vecs[12] = '{32'h0000_0020, 32'd48, 1, 0, 0, 32'h0,         0,  0, 32'h0000_0020, 32'd48, 32'h0,         32'h0,         1};
        vecs[13] = '{32'h8D09_0000, 32'd52, 1, 0, 0, 32'h0,         0,  0, 32'h8D09_0000, 32'd52, 32'hDEAD_BEEF, 32'h0000_0055, 1};
        vecs[14] = '{32'h012B_5020, 32'd56, 0, 0, 0, 32'h0,         0,  0, 32'h012B_5020, 32'd56, 32'h0000_0055, 32'h0,         0};

        // Reset state.
        repeat (2) @(negedge clk);
        check32("reset.ID_IR", bus.ID_IR, 32'h0);
        check32("reset.ID_PC_plus_4", bus.ID_PC_plus_4, 32'h0);
        check32("reset.ID_RegA", bus.ID_RegA, 32'h0);
        check32("reset.ID_RegB", bus.ID_RegB, 32'h0);
        check32("reset.ID_valid", {31'h0, bus.ID_valid}, 32'h0);
        check32("reset.Stall", {31'h0, bus.Stall}, 32'h0);
`ifdef ID_STALL_COUNT_EN
        check32("reset.stall_count", stallCount, 32'h0);
`endif
        reset = 1'b1;

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].ir, vecs[i].pc, vecs[i].valid, vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].flush);
            #1;
            check32($sformatf("vec%0d.Stall", i), {31'h0, bus.Stall}, {31'h0, vecs[i].expStall});
            push_exp(vecs[i].expIr, vecs[i].expPc, vecs[i].expA, vecs[i].expB, vecs[i].expValid);
            compare_out($sformatf("vec%0d", i));
        end
`ifdef ID_STALL_COUNT_EN
        // Only vec6 stalled without a flush.
        check32("stall_count.after_table", stallCount, 32'd1);
`endif

        // Async reset between edges while ID_valid=1.
        drive(32'h0108_4020, 32'd60, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        push_exp(32'h0108_4020, 32'd60, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        compare_out("pre_async");
        #2;
        reset = 1'b0;
        #1;
        check32("async.ID_valid", {31'h0, bus.ID_valid}, 32'h0);
        check32("async.ID_IR", bus.ID_IR, 32'h0);
        check32("async.Stall", {31'h0, bus.Stall}, 32'h0);
`ifdef ID_STALL_COUNT_EN
        check32("async.stall_count", stallCount, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        // GPR[8] is back to 0 and $sp to SP_INIT.
        drive(32'h011D_0020, 32'd64, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        check32("post_async.Stall", {31'h0, bus.Stall}, 32'h0);
        push_exp(32'h011D_0020, 32'd64, 32'h0, 32'h0000_07fc, 1'b1);
        compare_out("post_async");

        // Random reads with random WB writes. Opcode 0 keeps hazards out.
        for (int r = 0; r < 32; r++) model[r] = (r == 29) ? 32'h0000_07fc : 32'h0;
        for (int i = 0; i < 24; i++) begin
            logic [4:0]  rs, rt, wreg;
            logic        we;
            logic [31:0] wdata, ir, ea, eb;
            rs    = 5'($urandom_range(0, 31));
            rt    = 5'($urandom_range(0, 31));
            wreg  = 5'($urandom_range(0, 31));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            ir    = {6'b000000, rs, rt, 16'h0020};
            ea = (rs == 5'd0) ? 32'h0 : ((we && wreg == rs) ? wdata : model[rs]);
            eb = (rt == 5'd0) ? 32'h0 : ((we && wreg == rt) ? wdata : model[rt]);
            drive(ir, 32'(100 + 4 * i), 1'b1, we, wreg, wdata, 1'b0);
            push_exp(ir, 32'(100 + 4 * i), ea, eb, 1'b1);
            if (we && wreg != 5'd0) model[wreg] = wdata;
            compare_out($sformatf("rand%0d", i));
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
